cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// 16 lines of one 32-bit word each. Tag = addr[31:6], index = addr[5:2].
module cache_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  line_index,
    output logic        line_we,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [2:0] {StIdle, StCmp, StFill, StWrite, StResp} state_t;

    state_t      state;
    logic        req_we;
    logic [25:0] req_tag;
    logic [15:0] valid;
    logic [31:0] data_mem [16];
    logic [25:0] tag_mem  [16];

    logic hit;
    logic fill_done;

    // Lookup against the latched request; line_index holds the latched index outside IDLE.
    always_comb begin
        hit       = valid[line_index] && (tag_mem[line_index] == req_tag);
        fill_done = (state == StFill) && mem_ack;
        line_we   = !reset && (((state == StCmp) && req_we && hit) || fill_done);
    end

    // Data and tag arrays; writes only happen through line_we, which reset blocks.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[line_index] <= (state == StFill) ? mem_rdata : mem_wdata;
        end
        if (line_we && (state == StFill)) begin
            tag_mem[line_index] <= req_tag;
        end
    end

    // Main FSM with registered outputs, valid bits and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            valid      <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            line_index <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            req_we     <= 1'b0;
            req_tag    <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                StIdle: begin
                    // cpu_ready high here means the CPU is still releasing the last request.
                    if (cpu_req && !cpu_ready) begin
                        req_we     <= cpu_we;
                        req_tag    <= cpu_addr[31:6];
                        line_index <= cpu_addr[5:2];
                        mem_addr   <= cpu_addr & 32'hFFFF_FFFC;
                        mem_wdata  <= cpu_wdata;
                        state      <= StCmp;
                    end
                end
                StCmp: begin
                    if (hit) begin
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    end else begin
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                    end
                    if (req_we) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state   <= StWrite;
                    end else if (hit) begin
                        cpu_rdata <= data_mem[line_index];
                        state     <= StResp;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= StFill;
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        valid[line_index] <= 1'b1;
                        cpu_rdata         <= mem_rdata;
                        mem_req           <= 1'b0;
                        state             <= StResp;
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    cpu_ready  <= 1'b1;
                    line_index <= '0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
